vga_timing_pattern: RTL and testbench
=====================================

# vga_timing_pattern

Upstream video source for the HDMI transmit path. Generates VGA raster timing (hsync, vsync, data-enable) from free-running horizontal and vertical counters, and produces a 24-bit test-pattern pixel for each active position. Outputs feed the three per-channel TMDS encoders directly:
- hsync/vsync drive c0/c1 of the blue channel.
- de drives all three encoders.
- rgb[23:16]/[15:8]/[7:0] drive the red/green/blue data inputs.

## Interface
Parameters:
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch
- H_VALID, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch
- V_VALID, 480, active lines per frame
- V_FRONT, 10, vertical front porch
- SYNC_ACTIVE, 1'b1, level of hsync/vsync during the sync pulse

Ports:
- vga_clk  in  1  pixel clock
- sys_rst_n  in  1  reset; asynchronous, active-low
- mode  in  2  pattern select: 00 colorbar, 01 grey ramp, 10 checkerboard, 11 solid white
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  active-video enable
- rgb  out  24  pixel {R,G,B}; 0 outside active video
- pix_x  out  12  active column, 0..H_VALID-1; 0 when de=0
- pix_y  out  12  active row, 0..V_VALID-1; 0 when de=0
- frame_start  out  1  one-cycle pulse at the first active pixel of each frame

## Operation
Derived constants:
- H_TOTAL = H_SYNC+H_BACK+H_VALID+H_FRONT (800)
- V_TOTAL = V_SYNC+V_BACK+V_VALID+V_FRONT (525)

Counters:
- cnt_h (12 bit) counts 0..H_TOTAL-1 and wraps to 0.
- cnt_v (12 bit) increments only on the cycle cnt_h wraps; it wraps to 0 when cnt_v==V_TOTAL-1 and cnt_h==H_TOTAL-1.

Region order in each dimension: sync, back porch, active, front porch.
- Sync: cnt_h < H_SYNC (likewise cnt_v < V_SYNC).
- Active horizontal: H_SYNC+H_BACK ≤ cnt_h < H_SYNC+H_BACK+H_VALID.
- Active vertical: same form using the V_ constants.
- de is true only when both dimensions are active.

Pixel coordinates (when active):
- pix_x = cnt_h-(H_SYNC+H_BACK)
- pix_y = cnt_v-(V_SYNC+V_BACK)

Mode latch:
- mode is sampled into mode_q only when cnt_h==0 and cnt_v==0.
- A mode change therefore takes effect at the next frame boundary; a frame is never mixed.

Patterns (computed from pix_x/pix_y and mode_q):
- Colorbar (00): BAR_W = H_VALID/8 (integer division); bar = pix_x/BAR_W, clamped to 7. Bars 0..7 are FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Grey ramp (01): R=G=B=pix_x[9:2].
- Checkerboard (10): FFFFFF when pix_x[5]^pix_y[5]=1, else 000000 (32×32 squares).
- Solid white (11): FFFFFF.

rgb is forced to 000000 whenever de=0.

## Timing
- All outputs are registered. Outputs at edge n+1 reflect the counter state at edge n, giving a 1-cycle latency, and every output is mutually aligned.
- Reset values:
  - cnt_h = cnt_v = 0 and mode_q = 00.
  - hsync = vsync = ~SYNC_ACTIVE.
  - de = 0, rgb = 0, pix_x = pix_y = 0, frame_start = 0.
- Reset release: the first rising edge registers cnt state (0,0), so hsync and vsync go to SYNC_ACTIVE on that edge.
- hsync is SYNC_ACTIVE for exactly H_SYNC cycles per line.
- vsync is SYNC_ACTIVE for exactly V_SYNC×H_TOTAL cycles per frame. Its edges coincide with the hsync leading edge.
- de is high for H_VALID consecutive cycles on each of V_VALID lines. The line period is H_TOTAL cycles and the frame period is H_TOTAL×V_TOTAL cycles.
- frame_start coincides with the first de=1 cycle of the frame (pix_x=0, pix_y=0) and is high for exactly that cycle.
- Mode changes at any cycle other than (0,0) are ignored until the next (0,0).
- Mid-frame reset: all outputs go to their reset values asynchronously, and timing restarts from (0,0) after release.
- No handshake and no backpressure: the block free-runs continuously.

## Test plan
- Reset check: assert reset, release → hsync=vsync=0 during reset. One edge after release, hsync=vsync=1. de rises exactly 96+48=144 cycles after hsync rises on line 35 (the first active line).
- Period check, default params → hsync period 800 cycles with high width 96. vsync period 420000 cycles with high width 1600. 640 de cycles per line and 480 active lines per frame (307200 de cycles per frame).
- mode=00 → rgb:
  - pix_x 0..79 = FFFFFF
  - pix_x 80 = FFFF00
  - pix_x 559 = 0000FF
  - pix_x 560..639 = 000000
  - rgb=0 on every de=0 cycle
- Mode switch: mode switched 00→01 mid-frame → current frame stays colorbar. Next frame is the ramp, with rgb=020202 at pix_x=8 and rgb=9F9F9F at pix_x=639.
- mode=10 → (pix_x,pix_y)=(0,0) gives 000000, (32,0) gives FFFFFF, (32,32) gives 000000. frame_start is exactly one pulse per 420000 cycles, aligned to pix_x=pix_y=0.
- Mid-frame reset: reset at line 200, pixel 300 → outputs immediately at reset values. After release, the next frame_start occurs exactly 35×800+144+1 cycles later.

Source files
------------

// File: rtl/vga_timing_pattern.sv
// vga_timing_pattern
// Free-running VGA raster generator with a selectable 24-bit test pattern.
// Horizontal/vertical counters define the raster position. Every output is
// registered from the counter state of the previous cycle, so the outputs
// lag the counters by exactly one cycle and stay aligned with each other.
// The pattern select is latched once per frame at raster origin (0,0), so a
// frame never mixes two patterns.

module vga_timing_pattern #(
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   H_VALID     = 640,
  parameter int   H_FRONT     = 16,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter int   V_VALID     = 480,
  parameter int   V_FRONT     = 10,
  parameter logic SYNC_ACTIVE = 1'b1
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [1:0]  mode,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [23:0] rgb,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        frame_start
);

  // ---------------------------------------------------------------------
  // Raster geometry
  // ---------------------------------------------------------------------
  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int BAR_W   = H_VALID / 8;

  localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_SYNC_END  = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_END  = 12'(V_SYNC);
  localparam logic [11:0] H_ACT_START = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_ACT_END   = 12'(H_SYNC + H_BACK + H_VALID);
  localparam logic [11:0] V_ACT_START = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] V_ACT_END   = 12'(V_SYNC + V_BACK + V_VALID);

  localparam logic [1:0] MODE_COLORBAR = 2'b00;
  localparam logic [1:0] MODE_RAMP     = 2'b01;
  localparam logic [1:0] MODE_CHECKER  = 2'b10;
  localparam logic [1:0] MODE_WHITE    = 2'b11;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [11:0] cnt_h_reg, cnt_h_next;
  logic [11:0] cnt_v_reg, cnt_v_next;
  logic [1:0]  mode_q_reg, mode_q_next;

  logic        hsync_reg, hsync_next;
  logic        vsync_reg, vsync_next;
  logic        de_reg, de_next;
  logic [23:0] rgb_reg, rgb_next;
  logic [11:0] pix_x_reg, pix_x_next;
  logic [11:0] pix_y_reg, pix_y_next;
  logic        frame_start_reg, frame_start_next;

  // ---------------------------------------------------------------------
  // Decode of the current raster position
  // ---------------------------------------------------------------------
  logic        frame_origin;
  logic        h_sync_zone, v_sync_zone;
  logic        h_active, v_active, active;
  logic [11:0] act_x, act_y;

  // Horizontal counter wraps every line; vertical advances only on that wrap.
  always_comb begin
    cnt_h_next = cnt_h_reg + 12'd1;
    cnt_v_next = cnt_v_reg;
    if (cnt_h_reg == H_LAST) begin
      cnt_h_next = 12'd0;
      if (cnt_v_reg == V_LAST) begin
        cnt_v_next = 12'd0;
      end else begin
        cnt_v_next = cnt_v_reg + 12'd1;
      end
    end
  end

  // Region decode: sync, active window and in-window coordinates.
  always_comb begin
    frame_origin = (cnt_h_reg == 12'd0) && (cnt_v_reg == 12'd0);
    h_sync_zone  = (cnt_h_reg < H_SYNC_END);
    v_sync_zone  = (cnt_v_reg < V_SYNC_END);
    h_active     = (cnt_h_reg >= H_ACT_START) && (cnt_h_reg < H_ACT_END);
    v_active     = (cnt_v_reg >= V_ACT_START) && (cnt_v_reg < V_ACT_END);
    active       = h_active && v_active;
    act_x        = 12'd0;
    act_y        = 12'd0;
    if (active) begin
      act_x = cnt_h_reg - H_ACT_START;
      act_y = cnt_v_reg - V_ACT_START;
    end
  end

  // Pattern select only moves at the frame origin so a frame is never mixed.
  always_comb begin
    mode_q_next = mode_q_reg;
    if (frame_origin) begin
      mode_q_next = mode;
    end
  end

  // ---------------------------------------------------------------------
  // Colorbar index: a thermometer of column thresholds avoids a divider.
  // Bar k starts at column k*BAR_W; anything past the 8th edge stays bar 7.
  // ---------------------------------------------------------------------
  logic [7:1] bar_ge;
  logic [2:0] bar_idx;
  logic [23:0] bar_color;

  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_bar_edge
      localparam logic [11:0] BAR_EDGE = 12'(gi * BAR_W);
      assign bar_ge[gi] = (act_x >= BAR_EDGE);
    end
  endgenerate

  // Highest crossed threshold selects the bar.
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (bar_ge[i]) begin
        bar_idx = 3'(i);
      end
    end
  end

  // Standard eight-bar color sequence, brightest first.
  always_comb begin
    case (bar_idx)
      3'd0:    bar_color = 24'hFFFFFF;
      3'd1:    bar_color = 24'hFFFF00;
      3'd2:    bar_color = 24'h00FFFF;
      3'd3:    bar_color = 24'h00FF00;
      3'd4:    bar_color = 24'hFF00FF;
      3'd5:    bar_color = 24'hFF0000;
      3'd6:    bar_color = 24'h0000FF;
      default: bar_color = 24'h000000;
    endcase
  end

  // ---------------------------------------------------------------------
  // Other patterns
  // ---------------------------------------------------------------------
  logic [23:0] ramp_color;
  logic [23:0] checker_color;
  logic [23:0] pattern_color;

  // Grey ramp replicates the same byte on all three channels.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ramp_chan
      assign ramp_color[gi*8 +: 8] = act_x[9:2];
    end
  endgenerate

  // 32x32 checkerboard from bit 5 of each coordinate.
  always_comb begin
    checker_color = (act_x[5] ^ act_y[5]) ? WHITE : BLACK;
  end

  // Pattern mux; blanking forces black outside the active window.
  always_comb begin
    case (mode_q_reg)
      MODE_COLORBAR: pattern_color = bar_color;
      MODE_RAMP:     pattern_color = ramp_color;
      MODE_CHECKER:  pattern_color = checker_color;
      MODE_WHITE:    pattern_color = WHITE;
      default:       pattern_color = BLACK;
    endcase
  end

  // Next values for the registered outputs, all from the same raster state.
  always_comb begin
    hsync_next       = h_sync_zone ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_next       = v_sync_zone ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    de_next          = active;
    rgb_next         = active ? pattern_color : BLACK;
    pix_x_next       = act_x;
    pix_y_next       = act_y;
    frame_start_next = (cnt_h_reg == H_ACT_START) && (cnt_v_reg == V_ACT_START);
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  // Raster counters and the per-frame pattern latch.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h_reg  <= 12'd0;
      cnt_v_reg  <= 12'd0;
      mode_q_reg <= MODE_COLORBAR;
    end else begin
      cnt_h_reg  <= cnt_h_next;
      cnt_v_reg  <= cnt_v_next;
      mode_q_reg <= mode_q_next;
    end
  end

  // Output stage: one cycle behind the counters, all outputs aligned.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hsync_reg       <= ~SYNC_ACTIVE;
      vsync_reg       <= ~SYNC_ACTIVE;
      de_reg          <= 1'b0;
      rgb_reg         <= BLACK;
      pix_x_reg       <= 12'd0;
      pix_y_reg       <= 12'd0;
      frame_start_reg <= 1'b0;
    end else begin
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      de_reg          <= de_next;
      rgb_reg         <= rgb_next;
      pix_x_reg       <= pix_x_next;
      pix_y_reg       <= pix_y_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign de          = de_reg;
  assign rgb         = rgb_reg;
  assign pix_x       = pix_x_reg;
  assign pix_y       = pix_y_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_pattern.sv
// tb_vga_timing_pattern
// Drives a shortened raster (full 640-pixel line, few lines per frame) with
// randomized mode changes and checks every output cycle against an
// arithmetic model of the raster, plus targeted pattern and period checks.

module tb_vga_timing_pattern;

  localparam int HS = 16, HB = 8, HV = 640, HF = 8;
  localparam int VS = 2,  VB = 2, VV = 33,  VF = 1;
  localparam logic SA = 1'b1;
  localparam int HT    = HS + HB + HV + HF;
  localparam int VT    = VS + VB + VV + VF;
  localparam int FRAME = HT * VT;
  localparam int ACT_H = HS + HB;
  localparam int ACT_V = VS + VB;

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  localparam logic [51:0] RESET_VEC = {~SA, ~SA, 1'b0, 24'h0, 12'h0, 12'h0, 1'b0};

  logic        vga_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        hsync, vsync, de, frame_start;
  logic [23:0] rgb;
  logic [11:0] pix_x, pix_y;
  logic [51:0] got;

  assign got = {hsync, vsync, de, rgb, pix_x, pix_y, frame_start};

  always #5 vga_clk = ~vga_clk;

  vga_timing_pattern #(
    .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
    .SYNC_ACTIVE(SA)
  ) dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .mode(mode),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start)
  );

  int checks = 0;
  int passes = 0;
  int p = -1;                       // output index since reset release
  logic [1:0] plan [4] = '{2'b10, 2'b00, 2'b01, 2'b11};
  logic [1:0] fmode [8];            // mode seen at each frame origin

  // Observations taken over the second frame window [FRAME, 2*FRAME).
  int last_hs_rise, last_vs_rise, last_fs, hs_run, vs_run, de_run;
  logic hs_prev, vs_prev, de_prev;
  int hs_w_min, hs_w_max, hs_p_min, hs_p_max, vs_w, vs_p;
  int de_w_min, de_w_max, de_lines, de_total, fs_count, fs_p, vs_misalign;

  // Reference: position p of a free-running raster, pattern from frame mode.
  function automatic logic [51:0] model(input int pp, input logic [1:0] m);
    int h, v, x, y, bar;
    logic hs_e, vs_e, de_e, fs_e;
    logic [23:0] c;
    logic [7:0] g;
    h = pp % HT;
    v = (pp / HT) % VT;
    hs_e = (h < HS) ? SA : ~SA;
    vs_e = (v < VS) ? SA : ~SA;
    de_e = (h >= ACT_H) && (h < ACT_H + HV) && (v >= ACT_V) && (v < ACT_V + VV);
    x = de_e ? h - ACT_H : 0;
    y = de_e ? v - ACT_V : 0;
    c = 24'h0;
    if (de_e) begin
      case (m)
        2'b00: begin
          bar = x / (HV / 8);
          if (bar > 7) bar = 7;
          c = BARS[bar];
        end
        2'b01: begin
          g = 8'((x >> 2) & 255);
          c = {g, g, g};
        end
        2'b10: c = (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
        default: c = 24'hFFFFFF;
      endcase
    end
    fs_e = de_e && (x == 0) && (y == 0);
    return {hs_e, vs_e, de_e, c, 12'(x), 12'(y), fs_e};
  endfunction

  function automatic int pos(input int frame, input int x, input int y);
    return frame * FRAME + (ACT_V + y) * HT + ACT_H + x;
  endfunction

  task automatic clear_obs();
    last_hs_rise = -1; last_vs_rise = -1; last_fs = -1;
    hs_run = 0; vs_run = 0; de_run = 0;
    hs_prev = 1'b0; vs_prev = 1'b0; de_prev = 1'b0;
    hs_w_min = 1 << 30; hs_w_max = -1; hs_p_min = 1 << 30; hs_p_max = -1;
    vs_w = -1; vs_p = -1; de_w_min = 1 << 30; de_w_max = -1;
    de_lines = 0; de_total = 0; fs_count = 0; fs_p = -1; vs_misalign = 0;
  endtask

  task automatic observe();
    logic in_win, hs_on, vs_on, hs_rise;
    in_win  = (p >= FRAME) && (p < 2 * FRAME);
    hs_on   = (hsync === SA);
    vs_on   = (vsync === SA);
    hs_rise = hs_on && !hs_prev;
    if (hs_rise) begin
      if (in_win && last_hs_rise >= 0) begin
        if (p - last_hs_rise < hs_p_min) hs_p_min = p - last_hs_rise;
        if (p - last_hs_rise > hs_p_max) hs_p_max = p - last_hs_rise;
      end
      last_hs_rise = p;
      hs_run = 0;
    end
    if (hs_on) hs_run++;
    if (!hs_on && hs_prev && in_win) begin
      if (hs_run < hs_w_min) hs_w_min = hs_run;
      if (hs_run > hs_w_max) hs_w_max = hs_run;
    end
    if (vs_on && !vs_prev) begin
      if (in_win) begin
        vs_p = p - last_vs_rise;
        if (!hs_rise) vs_misalign++;
      end
      last_vs_rise = p;
      vs_run = 0;
    end
    if (vs_on) vs_run++;
    if (!vs_on && vs_prev && in_win) begin
      vs_w = vs_run;
      if (!hs_rise) vs_misalign++;
    end
    if (de === 1'b1 && !de_prev) de_run = 0;
    if (de === 1'b1) begin
      de_run++;
      if (in_win) de_total++;
    end
    if (de !== 1'b1 && de_prev && in_win) begin
      if (de_run < de_w_min) de_w_min = de_run;
      if (de_run > de_w_max) de_w_max = de_run;
      de_lines++;
    end
    if (frame_start === 1'b1) begin
      if (in_win) begin
        fs_count++;
        fs_p = p - last_fs;
      end
      last_fs = p;
    end
    hs_prev = hs_on;
    vs_prev = vs_on;
    de_prev = (de === 1'b1);
  endtask

  // Drive the mode for the next edge, advance one clock, sample #1 after.
  task automatic step();
    int nxt;
    nxt = p + 1;
    if (nxt % FRAME == 0) mode = plan[(nxt / FRAME) % 4];
    else if (nxt % FRAME == FRAME / 2) mode = plan[(nxt / FRAME + 1) % 4];
    else if ($urandom_range(0, 299) == 0) mode = 2'($urandom_range(0, 3));
    if (nxt % FRAME == 0) fmode[(nxt / FRAME) % 8] = mode;
    @(posedge vga_clk);
    #1;
    p = nxt;
    observe();
  endtask

  task automatic test_reset();
    logic [51:0] exp;
    sys_rst_n = 1'b0;
    repeat (3) begin
      mode = 2'($urandom_range(0, 3));
      @(posedge vga_clk);
      #1;
      checks++;
      if (got !== RESET_VEC) $display("FAIL reset_hold got=%h expected=%h", got, RESET_VEC);
      else passes++;
    end
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    p = -1;
    clear_obs();
    step();
    checks++;
    if (hsync !== SA) $display("FAIL release_hsync got=%b expected=%b", hsync, SA);
    else passes++;
    checks++;
    if (vsync !== SA) $display("FAIL release_vsync got=%b expected=%b", vsync, SA);
    else passes++;
    while (de !== 1'b1 && p < FRAME) begin
      exp = model(p, fmode[(p / FRAME) % 8]);
      checks++;
      if (got !== exp) $display("FAIL reset_cycle p=%0d got=%h expected=%h", p, got, exp);
      else passes++;
      step();
    end
    checks++;
    if (p != ACT_V * HT + ACT_H) $display("FAIL first_de_index got=%0d expected=%0d", p, ACT_V * HT + ACT_H);
    else passes++;
    checks++;
    if (p - last_hs_rise != ACT_H) $display("FAIL de_after_hsync got=%0d expected=%0d", p - last_hs_rise, ACT_H);
    else passes++;
  endtask

  task automatic test_checkerboard();
    logic [51:0] exp;
    int fs_seen;
    fs_seen = 0;
    while (p < FRAME - 1) begin
      exp = model(p, fmode[(p / FRAME) % 8]);
      checks++;
      if (got !== exp) $display("FAIL checker_cycle p=%0d got=%h expected=%h", p, got, exp);
      else passes++;
      if (frame_start === 1'b1) fs_seen++;
      if (p == pos(0, 0, 0)) begin
        checks++;
        if (rgb !== 24'h000000 || frame_start !== 1'b1)
          $display("FAIL checker_0_0 got=%h/%b expected=000000/1", rgb, frame_start);
        else passes++;
      end
      if (p == pos(0, 32, 0)) begin
        checks++;
        if (rgb !== 24'hFFFFFF) $display("FAIL checker_32_0 got=%h expected=ffffff", rgb);
        else passes++;
      end
      if (p == pos(0, 32, 32)) begin
        checks++;
        if (rgb !== 24'h000000) $display("FAIL checker_32_32 got=%h expected=000000", rgb);
        else passes++;
      end
      step();
    end
    checks++;
    if (fs_seen != 1) $display("FAIL frame0_start_count got=%0d expected=1", fs_seen);
    else passes++;
  endtask

  task automatic test_colorbar();
    logic [51:0] exp;
    int q, x;
    while (p < 2 * FRAME - 1) begin
      step();
      exp = model(p, fmode[(p / FRAME) % 8]);
      checks++;
      if (got !== exp) $display("FAIL colorbar_cycle p=%0d got=%h expected=%h", p, got, exp);
      else passes++;
      if (de !== 1'b1 && rgb !== 24'h0) begin
        checks++;
        $display("FAIL blank_rgb p=%0d got=%h expected=000000", p, rgb);
      end
      q = p - pos(1, 0, 0);
      if (q >= 0 && q < HV) begin
        x = q;
        checks++;
        if (x < 80 && rgb !== 24'hFFFFFF) $display("FAIL bar0 x=%0d got=%h expected=ffffff", x, rgb);
        else if (x == 80 && rgb !== 24'hFFFF00) $display("FAIL bar1_edge got=%h expected=ffff00", rgb);
        else if (x == 559 && rgb !== 24'h0000FF) $display("FAIL bar6_end got=%h expected=0000ff", rgb);
        else if (x >= 560 && rgb !== 24'h000000) $display("FAIL bar7 x=%0d got=%h expected=000000", x, rgb);
        else passes++;
      end
      if (p == pos(1, 80, VV - 1)) begin
        checks++;
        if (rgb !== 24'hFFFF00) $display("FAIL colorbar_after_switch got=%h expected=ffff00", rgb);
        else passes++;
      end
    end
  endtask

  task automatic test_periods();
    checks++;
    if (hs_w_min != HS || hs_w_max != HS) $display("FAIL hsync_width got=%0d..%0d expected=%0d", hs_w_min, hs_w_max, HS);
    else passes++;
    checks++;
    if (hs_p_min != HT || hs_p_max != HT) $display("FAIL hsync_period got=%0d..%0d expected=%0d", hs_p_min, hs_p_max, HT);
    else passes++;
    checks++;
    if (vs_w != VS * HT) $display("FAIL vsync_width got=%0d expected=%0d", vs_w, VS * HT);
    else passes++;
    checks++;
    if (vs_p != FRAME) $display("FAIL vsync_period got=%0d expected=%0d", vs_p, FRAME);
    else passes++;
    checks++;
    if (vs_misalign != 0) $display("FAIL vsync_hsync_align got=%0d expected=0", vs_misalign);
    else passes++;
    checks++;
    if (de_w_min != HV || de_w_max != HV) $display("FAIL de_width got=%0d..%0d expected=%0d", de_w_min, de_w_max, HV);
    else passes++;
    checks++;
    if (de_lines != VV) $display("FAIL de_lines got=%0d expected=%0d", de_lines, VV);
    else passes++;
    checks++;
    if (de_total != HV * VV) $display("FAIL de_total got=%0d expected=%0d", de_total, HV * VV);
    else passes++;
    checks++;
    if (fs_count != 1 || fs_p != FRAME) $display("FAIL frame_start_period got=%0d/%0d expected=1/%0d", fs_count, fs_p, FRAME);
    else passes++;
  endtask

  task automatic test_mode_switch();
    logic [51:0] exp;
    while (p < pos(2, HV, 0)) begin
      step();
      exp = model(p, fmode[(p / FRAME) % 8]);
      checks++;
      if (got !== exp) $display("FAIL ramp_cycle p=%0d got=%h expected=%h", p, got, exp);
      else passes++;
      if (p == pos(2, 8, 0)) begin
        checks++;
        if (rgb !== 24'h020202) $display("FAIL ramp_x8 got=%h expected=020202", rgb);
        else passes++;
      end
      if (p == pos(2, 300, 0)) begin
        checks++;
        if (rgb !== 24'h4B4B4B) $display("FAIL ramp_x300 got=%h expected=4b4b4b", rgb);
        else passes++;
      end
      if (p == pos(2, 639, 0)) begin
        checks++;
        if (rgb !== 24'h9F9F9F) $display("FAIL ramp_x639 got=%h expected=9f9f9f", rgb);
        else passes++;
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    logic [51:0] exp;
    int cnt;
    while (p < 2 * FRAME + 10 * HT + 300) begin
      step();
      exp = model(p, fmode[(p / FRAME) % 8]);
      checks++;
      if (got !== exp) $display("FAIL prereset_cycle p=%0d got=%h expected=%h", p, got, exp);
      else passes++;
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (got !== RESET_VEC) $display("FAIL async_reset got=%h expected=%h", got, RESET_VEC);
    else passes++;
    repeat (2) @(posedge vga_clk);
    #1;
    checks++;
    if (got !== RESET_VEC) $display("FAIL reset_held got=%h expected=%h", got, RESET_VEC);
    else passes++;
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    p = -1;
    clear_obs();
    cnt = 0;
    while (frame_start !== 1'b1 && cnt < FRAME) begin
      step();
      cnt++;
      exp = model(p, fmode[(p / FRAME) % 8]);
      checks++;
      if (got !== exp) $display("FAIL restart_cycle p=%0d got=%h expected=%h", p, got, exp);
      else passes++;
    end
    checks++;
    if (cnt != ACT_V * HT + ACT_H + 1) $display("FAIL restart_latency got=%0d expected=%0d", cnt, ACT_V * HT + ACT_H + 1);
    else passes++;
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_checkerboard();
    test_colorbar();
    test_periods();
    test_mode_switch();
    test_mid_frame_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
